// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control sequencer for the IMIPS core. It sits between the
// combinational opcode/funct decoder and the datapath. Each instruction steps
// through FETCH -> DECODE -> (EXEC | MDWAIT | INWAIT | OUTWAIT) -> WB. Decoder
// controls are turned into single-cycle write strobes. STOP parks the
// sequencer in HALT until reset.
//
// Parameters
//   FETCH_CYCLES  cycles spent in FETCH (instruction ROM latency), >= 1
//   MD_LATENCY    cycles spent in MDWAIT for mult/div, >= 1
//   CNT_W         width of the retired-instruction counter
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   1 = execute, 0 = stop at the next instruction boundary
//   regw[1:0]    in   decoder register-write field (nonzero = writes a reg)
//   aluop[4:0]   in   decoder ALU op (10000 = mult, 10001 = div)
//   memw         in   decoder memory-write flag
//   sleep        in   decoder STOP flag
//   inop         in   decoder IN flag
//   outop        in   decoder OUT flag
//   in_valid     in   input device has data ready
//   out_ready    in   output device can accept data
//   ir_we        out  load instruction register
//   pc_we        out  advance/update the PC
//   reg_we       out  register file write strobe
//   mem_we       out  data memory write strobe
//   in_ack       out  input datum consumed
//   out_valid    out  output datum presented
//   halted       out  STOP has executed
//   state[3:0]   out  current state, for debug
//   instr_count  out  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned FETCH_CYCLES = 1,
  parameter int unsigned MD_LATENCY   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [1:0]       regw,
  input  logic [4:0]       aluop,
  input  logic             memw,
  input  logic             sleep,
  input  logic             inop,
  input  logic             outop,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             mem_we,
  output logic             in_ack,
  output logic             out_valid,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned FC_W = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam int unsigned MD_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FETCH_CYCLES - 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 1);

  localparam logic [4:0] ALU_MULT = 5'b10000;
  localparam logic [4:0] ALU_DIV  = 5'b10001;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC    = 4'd3,
    MDWAIT  = 4'd4,
    INWAIT  = 4'd5,
    OUTWAIT = 4'd6,
    WB      = 4'd7,
    HALT    = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [MD_W-1:0]  mcnt_q, mcnt_d;
  logic             f_regw_q, f_regw_d;
  logic             f_memw_q, f_memw_d;
  logic             f_in_q, f_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ir_we_q, ir_we_d;
  logic pc_we_q, pc_we_d;
  logic reg_we_q, reg_we_d;
  logic mem_we_q, mem_we_d;
  logic in_ack_q, in_ack_d;
  logic out_valid_q, out_valid_d;
  logic halted_q, halted_d;

  logic is_md;
  assign is_md = (aluop == ALU_MULT) || (aluop == ALU_DIV);

  // Next-state logic. Decoder inputs are only looked at in DECODE; what WB
  // needs later is held in the f_* flags.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    mcnt_d   = mcnt_q;
    f_regw_d = f_regw_q;
    f_memw_d = f_memw_q;
    f_in_d   = f_in_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          fcnt_d  = FC_LOAD;
        end
      end

      FETCH: begin
        if (fcnt_q == '0) begin
          state_d = DECODE;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end

      DECODE: begin
        f_regw_d = (regw != 2'b00);
        f_memw_d = memw;
        f_in_d   = inop;
        if (sleep) begin
          state_d = HALT;
        end else if (inop) begin
          state_d = INWAIT;
        end else if (outop) begin
          state_d = OUTWAIT;
        end else if (is_md) begin
          state_d = MDWAIT;
          mcnt_d  = MD_LOAD;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = WB;
      end

      MDWAIT: begin
        if (mcnt_q == '0) begin
          state_d = WB;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end

      INWAIT: begin
        if (in_valid) begin
          state_d = WB;
        end
      end

      OUTWAIT: begin
        if (out_ready) begin
          state_d = WB;
        end
      end

      WB: begin
        cnt_d = cnt_q + 1'b1;
        if (run) begin
          state_d = FETCH;
          fcnt_d  = FC_LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output registers are loaded from the next-state values so that each
  // strobe is high in exactly the cycle its state is current, while still
  // coming straight out of a flop.
  always_comb begin
    ir_we_d     = (state_d == FETCH) && (fcnt_d == '0);
    pc_we_d     = (state_d == WB);
    reg_we_d    = (state_d == WB) && f_regw_d;
    mem_we_d    = (state_d == WB) && f_memw_d;
    in_ack_d    = (state_d == WB) && f_in_d;
    out_valid_d = (state_d == OUTWAIT);
    halted_d    = (state_d == HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      mcnt_q      <= '0;
      f_regw_q    <= 1'b0;
      f_memw_q    <= 1'b0;
      f_in_q      <= 1'b0;
      cnt_q       <= '0;
      ir_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      in_ack_q    <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      mcnt_q      <= mcnt_d;
      f_regw_q    <= f_regw_d;
      f_memw_q    <= f_memw_d;
      f_in_q      <= f_in_d;
      cnt_q       <= cnt_d;
      ir_we_q     <= ir_we_d;
      pc_we_q     <= pc_we_d;
      reg_we_q    <= reg_we_d;
      mem_we_q    <= mem_we_d;
      in_ack_q    <= in_ack_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign ir_we       = ir_we_q;
  assign pc_we       = pc_we_q;
  assign reg_we      = reg_we_q;
  assign mem_we      = mem_we_q;
  assign in_ack      = in_ack_q;
  assign out_valid   = out_valid_q;
  assign halted      = halted_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Table of instruction records (decoder inputs, device stall, expected timing
// and WB strobes) pushed to a scoreboard queue when driven and popped when
// the DUT reaches WB. Hand-written sequences cover STOP/HALT, reset during an
// OUT handshake and retired-count wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int unsigned FC = 1;
  localparam int unsigned MD = 4;
  localparam int unsigned CW = 10;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_MD    = 4'd4;
  localparam logic [3:0] S_IN    = 4'd5;
  localparam logic [3:0] S_OUT   = 4'd6;
  localparam logic [3:0] S_HALT  = 4'd8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic [1:0]    regw = '0;
  logic [4:0]    aluop = '0;
  logic          memw = 1'b0;
  logic          sleep = 1'b0;
  logic          inop = 1'b0;
  logic          outop = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          ir_we, pc_we, reg_we, mem_we, in_ack, out_valid, halted;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  instr_sequencer #(
    .FETCH_CYCLES(FC),
    .MD_LATENCY  (MD),
    .CNT_W       (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .regw       (regw),
    .aluop      (aluop),
    .memw       (memw),
    .sleep      (sleep),
    .inop       (inop),
    .outop      (outop),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .mem_we     (mem_we),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .halted     (halted),
    .state      (state),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  regw;
    logic [4:0]  aluop;
    logic        memw;
    logic        inop;
    logic        outop;
    logic        pre_valid;
    logic        drop_run;
    int unsigned wait_c;
    int unsigned exp_cyc;
    int unsigned exp_md;
    int unsigned exp_in;
    int unsigned exp_ov;
    logic        exp_reg;
    logic        exp_mem;
    logic        exp_ack;
  } vec_t;

  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;
  logic [CW-1:0] exp_count = '0;
  vec_t          tbl[14];
  vec_t          sb_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rg, input logic [4:0] al,
                              input logic mw, input logic ip, input logic op,
                              input logic pv, input logic dr, input int unsigned wc,
                              input int unsigned ec, input int unsigned em,
                              input int unsigned ei, input int unsigned eo,
                              input logic er, input logic eme, input logic ea);
    vec_t v;
    v.regw = rg; v.aluop = al; v.memw = mw; v.inop = ip; v.outop = op;
    v.pre_valid = pv; v.drop_run = dr; v.wait_c = wc;
    v.exp_cyc = ec; v.exp_md = em; v.exp_in = ei; v.exp_ov = eo;
    v.exp_reg = er; v.exp_mem = eme; v.exp_ack = ea;
    return v;
  endfunction

  task automatic wait_state(input logic [3:0] s, input string nm);
    int unsigned b = 0;
    while (state !== s && b < 40) begin
      @(negedge clock);
      b++;
    end
    check(nm, 32'(state), 32'(s));
  endtask

  // Drive one instruction and follow it to WB and one cycle beyond.
  // Entered and left on a negative clock edge.
  task automatic run_instr(input vec_t v, input int idx);
    int unsigned cyc = 0, budget = 0, n_ir = 0, ir_cyc = 0;
    int unsigned n_md = 0, n_in = 0, n_ost = 0, n_ov = 0;
    bit done = 1'b0;
    vec_t e;
    regw = v.regw; aluop = v.aluop; memw = v.memw; sleep = 1'b0;
    inop = v.inop; outop = v.outop;
    in_valid = v.pre_valid; out_ready = 1'b0; run = 1'b1;
    sb_q.push_back(v);
    while (!done && budget < 100) begin
      if (cyc == 0 && state == S_FETCH) cyc = 1;
      if (cyc != 0) begin
        check($sformatf("v%0d_excl_c%0d", idx, cyc),
              {29'd0, halted, ir_we & pc_we, (reg_we | mem_we | in_ack) & ~pc_we}, 32'd0);
        if (ir_we) begin n_ir++; ir_cyc = cyc; end
        if (state == S_MD) begin
          n_md++;
          if (v.drop_run) run = 1'b0;
        end
        if (state == S_IN) begin
          n_in++;
          if (n_in >= v.wait_c) in_valid = 1'b1;
        end
        if (state == S_OUT) begin
          n_ost++;
          if (out_valid) n_ov++;
          if (n_ost >= v.wait_c) out_ready = 1'b1;
        end
        if (pc_we) begin
          done = 1'b1;
          if (sb_q.size() == 0) begin
            check($sformatf("v%0d_sb_nonempty", idx), 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            exp_count = exp_count + 1'b1;
            check($sformatf("v%0d_wb_cycle", idx), cyc, e.exp_cyc);
            check($sformatf("v%0d_reg_we", idx), 32'(reg_we), 32'(e.exp_reg));
            check($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(e.exp_mem));
            check($sformatf("v%0d_in_ack", idx), 32'(in_ack), 32'(e.exp_ack));
            check($sformatf("v%0d_out_valid_wb", idx), 32'(out_valid), 32'd0);
            check($sformatf("v%0d_ir_we_count", idx), n_ir, 32'd1);
            check($sformatf("v%0d_ir_we_cycle", idx), ir_cyc, FC);
            check($sformatf("v%0d_md_cycles", idx), n_md, e.exp_md);
            check($sformatf("v%0d_in_cycles", idx), n_in, e.exp_in);
            check($sformatf("v%0d_out_valid_cycles", idx), n_ov, e.exp_ov);
          end
        end else begin
          cyc++;
        end
      end
      if (!done) begin
        @(negedge clock);
        budget++;
      end
    end
    check($sformatf("v%0d_reached_wb", idx), 32'(done), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d_after_wb_state", idx), 32'(state), 32'(run ? S_FETCH : S_IDLE));
    check($sformatf("v%0d_instr_count", idx), 32'(instr_count), 32'(exp_count));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_wb, budget;
    localparam int unsigned NWRAP = 1 << CW;

    tbl[0]  = mk(2'd3, 5'd1,  0, 0, 0, 0, 0, 0, FC + 3,      0,  0, 0, 1, 0, 0); // add
    tbl[1]  = mk(2'd3, 5'd16, 0, 0, 0, 0, 0, 0, FC + MD + 2, MD, 0, 0, 1, 0, 0); // mult
    tbl[2]  = mk(2'd3, 5'd17, 0, 0, 0, 0, 0, 0, FC + MD + 2, MD, 0, 0, 1, 0, 0); // div
    tbl[3]  = mk(2'd0, 5'd1,  1, 0, 0, 0, 0, 0, FC + 3,      0,  0, 0, 0, 1, 0); // store
    tbl[4]  = mk(2'd0, 5'd6,  0, 0, 0, 0, 0, 0, FC + 3,      0,  0, 0, 0, 0, 0); // branch
    tbl[5]  = mk(2'd0, 5'd0,  1, 1, 0, 0, 0, 5, FC + 2 + 5,  0,  5, 0, 0, 1, 1); // IN, 5-cycle stall
    tbl[6]  = mk(2'd0, 5'd0,  0, 0, 1, 0, 0, 4, FC + 2 + 4,  0,  0, 4, 0, 0, 0); // OUT, ready low 3
    tbl[7]  = mk(2'd0, 5'd0,  0, 0, 1, 0, 0, 1, FC + 3,      0,  0, 1, 0, 0, 0); // OUT, ready high
    tbl[8]  = mk(2'd3, 5'd1,  0, 0, 0, 1, 0, 0, FC + 3,      0,  0, 0, 1, 0, 0); // add, in_valid high
    tbl[9]  = mk(2'd1, 5'd0,  0, 1, 0, 1, 0, 1, FC + 3,      0,  1, 0, 1, 0, 1); // IN, in_valid early
    tbl[10] = mk(2'd2, 5'd16, 0, 0, 0, 0, 1, 0, FC + MD + 2, MD, 0, 0, 1, 0, 0); // mult, run dropped
    tbl[11] = mk(2'd3, 5'd1,  0, 0, 0, 0, 0, 0, FC + 3,      0,  0, 0, 1, 0, 0); // add from IDLE
    tbl[12] = mk(2'd0, 5'd16, 0, 0, 1, 0, 0, 2, FC + 2 + 2,  0,  0, 2, 0, 0, 0); // OUT beats mult
    tbl[13] = mk(2'd0, 5'd0,  1, 1, 1, 0, 0, 2, FC + 2 + 2,  0,  2, 0, 0, 1, 1); // IN beats OUT

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_outputs", {25'd0, ir_we, pc_we, reg_we, mem_we, in_ack, out_valid, halted}, 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_holds_without_run", 32'(state), 32'(S_IDLE));

    for (int i = 0; i < 14; i++) run_instr(tbl[i], i);

    // STOP with IN also set: HALT wins, nothing retires, run is ignored
    regw = 2'd3; aluop = 5'd16; memw = 1'b1; sleep = 1'b1; inop = 1'b1; outop = 1'b0; run = 1'b1;
    wait_state(S_HALT, "stop_reaches_halt");
    check("stop_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 8; i++) begin
      run = i[0];
      @(negedge clock);
      check($sformatf("halt_hold_%0d", i),
            {state, 7'd0, halted, pc_we, reg_we, mem_we, ir_we, in_ack, 22'(instr_count)},
            {S_HALT, 7'd0, 1'b1, 5'b00000, 22'(exp_count)});
    end
    #2 reset_n = 1'b0;
    sleep = 1'b0; inop = 1'b0; run = 1'b0; memw = 1'b0;
    #1 check("halt_reset_clears", {27'd0, state, halted}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_count = '0;

    // Reset in the middle of an OUT handshake
    regw = 2'd0; aluop = 5'd0; outop = 1'b1; out_ready = 1'b0; run = 1'b1;
    wait_state(S_OUT, "out_reaches_outwait");
    repeat (2) @(negedge clock);
    check("out_valid_during_stall", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_state", 32'(state), 32'(S_IDLE));
    check("async_reset_strobes", {26'd0, ir_we, pc_we, reg_we, mem_we, in_ack, halted}, 32'd0);
    outop = 1'b0; run = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("post_reset_quiet_%0d", i),
            {state, 21'd0, ir_we, pc_we, reg_we, mem_we, in_ack, out_valid, halted}, 32'd0);
    end
    check("post_reset_count", 32'(instr_count), 32'd0);

    // Retired counter wraps after 2^CW instructions
    regw = 2'd3; aluop = 5'd1; run = 1'b1;
    n_wb = 0; budget = 0;
    while (n_wb < NWRAP && budget < NWRAP * (FC + 3) + 50) begin
      @(negedge clock);
      budget++;
      if (pc_we) begin
        n_wb++;
        if (n_wb == NWRAP) begin
          check("count_before_wrap", 32'(instr_count), NWRAP - 1);
          run = 1'b0;
        end
      end
    end
    check("wrap_instructions_retired", n_wb, NWRAP);
    @(negedge clock);
    check("count_wrapped", 32'(instr_count), 32'd0);
    check("idle_after_wrap", 32'(state), 32'(S_IDLE));

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the IMIPS core; sits between the combinational opcode/funct decoder and the datapath.
- Steps each instruction through fetch, decode, execute and writeback, and turns decoder control signals into single-cycle write strobes.
- Stalls for multi-cycle mult/div, the IN (Get) and OUT (Print) device handshakes, and the STOP halt.

Parameters:
FETCH_CYCLES, 1, cycles spent in FETCH (instruction ROM latency); legal range >= 1
MD_LATENCY, 4, cycles spent in MDWAIT for mult/div; legal range >= 1
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary
regw  in  2  decoder register-write field; nonzero means the instruction writes a register
aluop  in  5  decoder ALU op; 5'b10000 = mult, 5'b10001 = div
memw  in  1  decoder memory-write flag
sleep  in  1  decoder STOP flag
inop  in  1  decoder IN flag
outop  in  1  decoder OUT flag
in_valid  in  1  input device has data ready
out_ready  in  1  output device can accept data
ir_we  out  1  load instruction register
pc_we  out  1  advance/update the PC (next-PC mux is in the datapath)
reg_we  out  1  register file write strobe
mem_we  out  1  data memory write strobe
in_ack  out  1  input datum consumed
out_valid  out  1  output datum presented
halted  out  1  STOP has executed
state  out  4  current state, for debug
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MDWAIT=4, INWAIT=5, OUTWAIT=6, WB=7, HALT=8.
- Outputs: all are Moore, decoded from registered state and registered flags only. No combinational path from any input to any output.
- Reset (asynchronous, reset_n=0): state=IDLE; every strobe, in_ack, out_valid and halted = 0; instr_count=0; fetch and MD counters = 0. Takes effect immediately, including mid-instruction or mid-handshake. No partial strobe may follow reset release.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: stay FETCH_CYCLES cycles. ir_we=1 on the last FETCH cycle only. Then go to DECODE.
- DECODE (1 cycle):
  - Capture regw!=0, memw, inop, the mult/div condition and sleep into internal flags. Decoder inputs need only be valid during this cycle.
  - Next state by priority: sleep -> HALT; else inop -> INWAIT; else outop -> OUTWAIT; else (aluop is 5'b10000 or 5'b10001) -> MDWAIT, loading the counter with MD_LATENCY-1; else -> EXEC.
- EXEC: 1 cycle, then WB.
- MDWAIT: decrement the counter each cycle. Go to WB in the cycle the counter reads 0. Total stay = MD_LATENCY cycles.
- INWAIT:
  - Wait for in_valid=1, then go to WB.
  - in_valid seen before INWAIT is ignored. in_valid is level-sampled, so no edge is required.
- OUTWAIT:
  - out_valid=1 for the whole stay; it never drops before transfer.
  - Transfer on the edge where out_valid=1 and out_ready=1, then go to WB.
  - If out_ready is held high, the stay is exactly 1 cycle.
- WB (1 cycle):
  - pc_we=1.
  - reg_we = captured regw!=0.
  - mem_we = captured memw.
  - in_ack=1 only if the captured instruction is IN.
  - instr_count increments and wraps modulo 2^CNT_W.
  - Next state: FETCH if run=1, else IDLE.
- run=0 mid-instruction: the current instruction still completes through WB, then the sequencer goes to IDLE. No abort.
- HALT:
  - halted=1; all strobes 0; no pc_we.
  - instr_count does not increment for STOP.
  - Exit only via reset; run is ignored.
- Cycles per instruction (defaults): ALU/move/branch = FETCH_CYCLES+3 = 4; mult/div = FETCH_CYCLES+MD_LATENCY+2 = 7; IN/OUT = 4 plus stall cycles.
- Mutual exclusion: at most one of reg_we/mem_we/pc_we-producing states is active in any cycle. ir_we and pc_we are never high together.

Test Plan:
- Reset, then run=1 with add (regw=11, aluop=00001): ir_we in cycle 1, reg_we=pc_we=1 in cycle 4 only, instr_count=1, state back to FETCH.
- mult (aluop=10000) with MD_LATENCY=4: exactly 4 MDWAIT cycles, WB in cycle 7, reg_we=1; div (10001) gives the same timing.
- IN (inop=1, memw=1) with in_valid raised 5 cycles after DECODE: state=INWAIT for 5 cycles, then WB with mem_we=1, in_ack=1 and reg_we=0.
- OUT with out_ready low for 3 cycles: out_valid held 4 cycles, drops after transfer, WB has pc_we=1 and mem_we=0. Separately, assert reset_n=0 during OUTWAIT: out_valid=0 immediately and state=0.
- STOP (sleep=1, inop=1 together): priority sends it to HALT, halted=1, no pc_we, instr_count unchanged, and run toggling has no effect.
- run dropped during MDWAIT: WB still executes, then IDLE. Count 2^16 retired instructions: instr_count wraps to 0.
